// File: rtl/mux2_stream_arbiter.sv
// Two-input, packet-aware round-robin stream arbiter with a registered output stage.
// It locks the grant for a whole packet and drives the downstream 2:1 mux select.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no packet owns the channel; arbitrate between A and B
// LOCK_A | A owns the channel until its last beat is accepted
// LOCK_B | B owns the channel until its last beat is accepted
module mux2_stream_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy,
    output logic [CNT_W-1:0]  a_pkt_cnt,
    output logic [CNT_W-1:0]  b_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;        // 0 favours A, 1 favours B
    logic   ptr_nxt;
    logic   sel_nxt;
    logic   a_fire;
    logic   b_fire;
    logic   load;

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;
    assign load   = a_fire || b_fire;
    assign busy   = (state != IDLE);

    // Next-state, grant and ready generation; ready depends only on registered state and out_ready.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || !ptr)) begin
                    state_nxt = LOCK_A;
                    sel_nxt   = 1'b0;
                end else if (b_valid) begin
                    state_nxt = LOCK_B;
                    sel_nxt   = 1'b1;
                end
            end
            LOCK_A: begin
                a_ready = !out_valid || out_ready;
                if (a_valid && a_ready && a_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b1;
                end
            end
            LOCK_B: begin
                b_ready = !out_valid || out_ready;
                if (b_valid && b_ready && b_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant pointer, output stage and packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            a_pkt_cnt <= '0;
            b_pkt_cnt <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            // sel already points at the locked source, so it doubles as the beat mux select
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sel ? b_data : a_data;
                out_last  <= sel ? b_last : a_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (a_fire && a_last) begin
                a_pkt_cnt <= a_pkt_cnt + CNT_W'(1);
            end
            if (b_fire && b_last) begin
                b_pkt_cnt <= b_pkt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: queue-fed sources, scoreboard on the merged output.
module tb_mux2_stream_arbiter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_last;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_last;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              sel;
    logic              busy;
    logic [CNT_W-1:0]  a_pkt_cnt;
    logic [CNT_W-1:0]  b_pkt_cnt;

    mux2_stream_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .a_pkt_cnt (a_pkt_cnt),
        .b_pkt_cnt (b_pkt_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] a_src[$];   // {last, data} beats waiting to be offered by A
    logic [8:0] b_src[$];
    logic [8:0] sb[$];      // expected merged output, in order
    logic       a_pause = 1'b0;
    logic       b_pause = 1'b0;
    logic [CNT_W-1:0] exp_a = '0;
    logic [CNT_W-1:0] exp_b = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every downstream handshake must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_beat unexpected: got last=%0b data=%02h, expected none", out_last, out_data);
            end else begin
                logic [8:0] exp_beat;
                exp_beat = sb.pop_front();
                if ({out_last, out_data} !== exp_beat) begin
                    errors++;
                    $display("FAIL out_beat: got last=%0b data=%02h, expected last=%0b data=%02h",
                             out_last, out_data, exp_beat[8], exp_beat[7:0]);
                end
            end
        end
    end

    // One clock: note input handshakes before the edge, then present the next beats after it.
    task automatic cycle();
        logic af;
        logic bf;
        @(negedge clk);
        af = !rst && a_valid && a_ready;
        bf = !rst && b_valid && b_ready;
        @(posedge clk);
        #1;
        if (af && a_src.size() > 0) void'(a_src.pop_front());
        if (bf && b_src.size() > 0) void'(b_src.pop_front());
        a_valid = (a_src.size() > 0) && !a_pause;
        a_data  = (a_src.size() > 0) ? a_src[0][7:0] : 8'h00;
        a_last  = (a_src.size() > 0) ? a_src[0][8] : 1'b0;
        b_valid = (b_src.size() > 0) && !b_pause;
        b_data  = (b_src.size() > 0) ? b_src[0][7:0] : 8'h00;
        b_last  = (b_src.size() > 0) ? b_src[0][8] : 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        a_src.delete();
        b_src.delete();
        a_pause = 1'b0;
        b_pause = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        rst   = 1'b0;
        exp_a = '0;
        exp_b = '0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && a_src.size() == 0 && b_src.size() == 0 && !busy) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0 || a_src.size() != 0 || b_src.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d beats still expected, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'hFF;
        b_data    = 8'hEE;
        a_last    = 1'b0;
        b_last    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sel, busy, out_valid, a_ready, b_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got sel=%0b busy=%0b ov=%0b ar=%0b br=%0b, expected all 0",
                     sel, busy, out_valid, a_ready, b_ready);
        end
        checks++;
        if (a_pkt_cnt !== '0 || b_pkt_cnt !== '0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got acnt=%0d bcnt=%0d data=%02h last=%0b, expected 0",
                     a_pkt_cnt, b_pkt_cnt, out_data, out_last);
        end
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b ov=%0b, expected 0", busy, out_valid);
        end
    endtask

    task automatic test_single();
        a_src.push_back({1'b0, 8'h11});
        a_src.push_back({1'b0, 8'h22});
        a_src.push_back({1'b1, 8'h33});
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b0, 8'h22});
        sb.push_back({1'b1, 8'h33});
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got busy=%0b ov=%0b sel=%0b, expected 1 0 0", busy, out_valid, sel);
        end
        cycle();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h11}) begin
            errors++;
            $display("FAIL single_beat0: got ov=%0b last=%0b data=%02h, expected 1 0 11", out_valid, out_last, out_data);
        end
        cycle();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h22}) begin
            errors++;
            $display("FAIL single_beat1: got ov=%0b last=%0b data=%02h, expected 1 0 22", out_valid, out_last, out_data);
        end
        cycle();
        exp_a = exp_a + 1'b1;
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h33} || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_beat2: got ov=%0b last=%0b data=%02h busy=%0b, expected 1 1 33 0",
                     out_valid, out_last, out_data, busy);
        end
        checks++;
        if (a_pkt_cnt !== exp_a || sel !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: got acnt=%0d sel=%0b, expected %0d 0", a_pkt_cnt, sel, exp_a);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_end: got ov=%0b pending=%0d, expected 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic seq[$];
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            a_src.push_back({1'b0, 8'hA0});
            a_src.push_back({1'b1, 8'hA1});
            b_src.push_back({1'b0, 8'hB0});
            b_src.push_back({1'b1, 8'hB1});
            sb.push_back({1'b0, 8'hA0});
            sb.push_back({1'b1, 8'hA1});
            sb.push_back({1'b0, 8'hB0});
            sb.push_back({1'b1, 8'hB1});
        end
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (busy && (seq.size() == 0 || seq[$] != sel)) seq.push_back(sel);
            if (sb.size() == 0 && a_src.size() == 0 && b_src.size() == 0 && !busy) break;
        end
        exp_a = exp_a + 2'd2;
        exp_b = exp_b + 2'd2;
        checks++;
        if (seq.size() != 4 || seq[0] !== 1'b0 || seq[1] !== 1'b1 || seq[2] !== 1'b0 || seq[3] !== 1'b1) begin
            errors++;
            $display("FAIL rr_sel: got %0d grants starting sel=%0b, expected 4 grants 0,1,0,1",
                     seq.size(), (seq.size() > 0) ? seq[0] : 1'bx);
        end
        checks++;
        if (a_pkt_cnt !== exp_a || b_pkt_cnt !== exp_b || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_cnt: got acnt=%0d bcnt=%0d pending=%0d, expected %0d %0d 0",
                     a_pkt_cnt, b_pkt_cnt, sb.size(), exp_a, exp_b);
        end
    endtask

    task automatic test_backpressure();
        a_src.push_back({1'b0, 8'h41});
        a_src.push_back({1'b0, 8'h42});
        a_src.push_back({1'b0, 8'h43});
        a_src.push_back({1'b1, 8'h44});
        sb.push_back({1'b0, 8'h41});
        sb.push_back({1'b0, 8'h42});
        sb.push_back({1'b0, 8'h43});
        sb.push_back({1'b1, 8'h44});
        cycle();
        cycle();
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h42 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got ov=%0b data=%02h ar=%0b, expected 1 42 0", out_valid, out_data, a_ready);
            end
        end
        out_ready = 1'b1;
        drain("bp_drain", 30);
        exp_a = exp_a + 1'b1;
        checks++;
        if (a_pkt_cnt !== exp_a) begin
            errors++;
            $display("FAIL bp_cnt: got acnt=%0d, expected %0d", a_pkt_cnt, exp_a);
        end
    endtask

    task automatic test_lock_hold();
        a_src.push_back({1'b0, 8'h51});
        a_src.push_back({1'b0, 8'h52});
        a_src.push_back({1'b1, 8'h53});
        sb.push_back({1'b0, 8'h51});
        sb.push_back({1'b0, 8'h52});
        sb.push_back({1'b1, 8'h53});
        sb.push_back({1'b1, 8'h61});
        cycle();
        cycle();
        a_pause = 1'b1;
        b_src.push_back({1'b1, 8'h61});
        cycle();
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (b_ready !== 1'b0 || sel !== 1'b0 || busy !== 1'b1 || b_valid !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold: got br=%0b sel=%0b busy=%0b, expected 0 0 1", b_ready, sel, busy);
            end
        end
        a_pause = 1'b0;
        drain("lock_drain", 40);
        exp_a = exp_a + 1'b1;
        exp_b = exp_b + 1'b1;
        checks++;
        if (a_pkt_cnt !== exp_a || b_pkt_cnt !== exp_b) begin
            errors++;
            $display("FAIL lock_cnt: got acnt=%0d bcnt=%0d, expected %0d %0d", a_pkt_cnt, b_pkt_cnt, exp_a, exp_b);
        end
    endtask

    task automatic test_reset_mid_packet();
        a_src.push_back({1'b0, 8'h71});
        a_src.push_back({1'b0, 8'h72});
        a_src.push_back({1'b0, 8'h73});
        a_src.push_back({1'b1, 8'h74});
        sb.push_back({1'b0, 8'h71});
        sb.push_back({1'b0, 8'h72});
        cycle();
        cycle();
        cycle();
        cycle();
        apply_reset();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || a_ready !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got busy=%0b ov=%0b ar=%0b sel=%0b, expected 0", busy, out_valid, a_ready, sel);
        end
        checks++;
        if (a_pkt_cnt !== exp_a || b_pkt_cnt !== exp_b) begin
            errors++;
            $display("FAIL midrst_cnt: got acnt=%0d bcnt=%0d, expected 0 0", a_pkt_cnt, b_pkt_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        for (int p = 0; p < 5; p++) begin
            logic [7:0] d;
            d = 8'h80 + 8'(p);
            a_src.push_back({1'b1, d});
            sb.push_back({1'b1, d});
        end
        drain("wrap_drain", 60);
        exp_a = exp_a + 3'd5;
        checks++;
        if (a_pkt_cnt !== exp_a || exp_a !== 2'd1) begin
            errors++;
            $display("FAIL wrap_cnt: got acnt=%0d, expected %0d", a_pkt_cnt, exp_a);
        end
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = '0;
        b_data    = '0;
        a_last    = 1'b0;
        b_last    = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock_hold();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
